fault_aggregator: RTL and testbench
===================================

// Module: fault_aggregator
// PURPOSE
//  Parametrised successor to the coffee-machine error handler. Collects NUM_ERR
//  error and NUM_WARN warning conditions from consumables, water and system logic.
//  Persistence-filters each channel and latches errors until acknowledged.
//  Produces critical/present flags, counts, a rotating display index for the
//  LCD/HEX path, and a system health FSM for the brew controller.
// PARAMETERS
//  NUM_ERR     6            number of error channels (1..16)
//  NUM_WARN    6            number of warning channels (1..16)
//  CRIT_MASK   {NUM_ERR{1}} error bits that contribute to critical_error
//  FILTER_CYC  4            consecutive cycles a raw input must differ before filtered value flips (>=1)
//  ROTATE_CYC  50_000_000   display dwell per active error, cycles (>=2)
//  RECOVER_CYC 1024         quiet time in RECOVER before leaving it (>=1)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          async active-high reset
//  err_raw        in   NUM_ERR    raw error conditions, active high
//  warn_raw       in   NUM_WARN   raw warning conditions, active high
//  clear          in   1          acknowledge pulse (1 cycle), clears inactive latched errors
//  err_latched    out  NUM_ERR    sticky filtered errors
//  warn_active    out  NUM_WARN   filtered warnings (non-sticky)
//  critical_error out  1          |(err_latched & CRIT_MASK)
//  error_present  out  1          |err_latched
//  error_count    out  $clog2(NUM_ERR+1)   popcount(err_latched)
//  warning_count  out  $clog2(NUM_WARN+1)  popcount(warn_active)
//  disp_valid     out  1          disp_id names a latched error
//  disp_id        out  $clog2(NUM_ERR)     index of error currently displayed
//  sys_state      out  2          health FSM state (fault_agg_pkg::state_t)
// BEHAVIOUR
//  - Reset: every output 0, sys_state=S_OK, filters/timers cleared; applies mid-operation too.
//    Still-present raw faults re-latch FILTER_CYC cycles after release.
//  - Filter: per channel, filtered flips after raw != filtered on FILTER_CYC consecutive edges.
//    Counter zeroes whenever raw == filtered (glitch shorter than FILTER_CYC ignored).
//  - Error latch: set on the edge where filtered error is 1. Cleared only when clear=1 and filtered=0.
//    clear while filtered=1 has no effect on that bit (set wins).
//  - warn_active = filtered warning, no latching.
//  - critical_error, error_present, counts: combinational from registered latches/filters,
//    so they are valid the same cycle as err_latched.
//  - Rotator:
//    * disp_valid=0, disp_id=0 when err_latched==0.
//    * First error latched: disp_id = lowest set index next cycle.
//    * Every ROTATE_CYC cycles: advance to next higher set index, wrapping to the lowest.
//    * If disp_id's bit clears: advance on the next cycle and restart the dwell timer.
//    * Single active error: disp_id holds.
//  - FSM (registered, evaluated each edge):
//    * S_OK      -> S_FAULT if error_present, else S_WARN if |warn_active.
//    * S_WARN    -> S_FAULT if error_present; -> S_OK if warnings gone.
//    * S_FAULT   -> S_RECOVER when err_latched==0.
//    * S_RECOVER -> S_FAULT immediately if any error relatches.
//    * S_RECOVER, after RECOVER_CYC quiet cycles -> S_WARN if warnings, else S_OK.
//    * Timer restarts on each RECOVER entry.
//  - Encoding: S_OK=0, S_WARN=1, S_FAULT=2, S_RECOVER=3.
// CONFIGURATION
//  FAULT_AGG_HISTORY_EN defined:
//   - extra ports hist_sel (in, $clog2(NUM_ERR)) and hist_count (out, 8).
//   - Per-error saturating 8-bit occurrence counter increments on each 0->1 of err_latched.
//   - Saturates at 255; cleared only by rst.
//   - hist_count = counter[hist_sel], combinational.
//   - hist_sel >= NUM_ERR returns 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  fault_agg_pkg: state_t enum, popcount function, default mask/width localparams.
//  Sub-module fault_filter: one debounced channel, param FILTER_CYC.
//   Instantiated NUM_ERR+NUM_WARN times via generate.
//  Latches, rotator, FSM stay in this module.
// TESTING (FILTER_CYC=4, ROTATE_CYC=8, RECOVER_CYC=16, NUM_ERR=NUM_WARN=6)
//  1. err_raw[2] pulse 3 cycles -> err_latched stays 0.
//     Held 4 cycles -> err_latched[2]=1, critical_error=1, sys_state=S_FAULT.
//  2. err_raw[2] held high, clear pulse -> err_latched[2] stays 1.
//     err_raw drop, wait 4, clear -> 0; sys_state S_RECOVER.
//     After 16 cycles -> S_OK.
//  3. Latch errors 1,4,5 -> disp_id 1,4,5,1 every 8 cycles.
//     Clear 4 while displayed -> next cycle disp_id=5.
//  4. warn_raw=6'b000011 only -> warning_count=2, sys_state=S_WARN, critical_error=0.
//     Then err 0 -> S_FAULT.
//  5. In S_RECOVER, re-raise err_raw[3] -> S_FAULT after filter.
//     rst mid-fault -> all outputs 0, S_OK.
//     Relatch 4 cycles after release.
//  6. (FAULT_AGG_HISTORY_EN) latch/clear err 0 three times -> hist_sel=0 gives hist_count=3.
//     300 toggles -> 255.

Source files
------------

// File: rtl/fault_agg_pkg.sv
// Shared types and helpers for the fault aggregator: health FSM encoding,
// default channel counts and a popcount used for the error/warning counts.
package fault_agg_pkg;

  typedef enum logic [1:0] {
    S_OK      = 2'd0,
    S_WARN    = 2'd1,
    S_FAULT   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam int DEF_NUM_ERR  = 6;
  localparam int DEF_NUM_WARN = 6;
  localparam int MAX_CHANNELS = 16;

  function automatic logic [4:0] popcount(input logic [MAX_CHANNELS-1:0] v);
    logic [4:0] sum;
    sum = 5'd0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      sum = sum + {4'd0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/fault_filter.sv
// One persistence-filtered channel: the filtered value follows raw only after
// raw has disagreed with it on FILTER_CYC consecutive clock edges.
module fault_filter #(
  parameter int FILTER_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered,
  output logic filt_next
);

  localparam int CW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYC - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          filtered_r;
  logic          filt_next_s;

  // Any agreement between raw and filtered restarts the persistence count.
  always_comb begin
    cnt_next_s  = '0;
    filt_next_s = filtered_r;
    if (raw != filtered_r) begin
      if (cnt_r == LAST) begin
        filt_next_s = raw;
        cnt_next_s  = '0;
      end else begin
        cnt_next_s  = cnt_r + CW'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= '0;
      filtered_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      filtered_r <= filt_next_s;
    end
  end

  assign filtered  = filtered_r;
  assign filt_next = filt_next_s;

endmodule

// File: rtl/fault_aggregator.sv
// Error/warning aggregator: filtering, sticky error latches, display rotator and
// health FSM. Define FAULT_AGG_HISTORY_EN for per-error occurrence counters.
module fault_aggregator
  import fault_agg_pkg::*;
#(
  parameter int                 NUM_ERR     = DEF_NUM_ERR,
  parameter int                 NUM_WARN    = DEF_NUM_WARN,
  parameter logic [NUM_ERR-1:0] CRIT_MASK   = {NUM_ERR{1'b1}},
  parameter int                 FILTER_CYC  = 4,
  parameter int                 ROTATE_CYC  = 50_000_000,
  parameter int                 RECOVER_CYC = 1024
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_ERR-1:0]                          err_raw,
  input  logic [NUM_WARN-1:0]                         warn_raw,
  input  logic                                        clear,
  output logic [NUM_ERR-1:0]                          err_latched,
  output logic [NUM_WARN-1:0]                         warn_active,
  output logic                                        critical_error,
  output logic                                        error_present,
  output logic [$clog2(NUM_ERR+1)-1:0]                error_count,
  output logic [$clog2(NUM_WARN+1)-1:0]               warning_count,
  output logic                                        disp_valid,
  output logic [((NUM_ERR > 1) ? $clog2(NUM_ERR) : 1)-1:0] disp_id,
`ifdef FAULT_AGG_HISTORY_EN
  input  logic [((NUM_ERR > 1) ? $clog2(NUM_ERR) : 1)-1:0] hist_sel,
  output logic [7:0]                                  hist_count,
`endif
  output state_t                                      sys_state
);

  localparam int ID_W = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1;
  localparam int EC_W = $clog2(NUM_ERR + 1);
  localparam int WC_W = $clog2(NUM_WARN + 1);
  localparam int DW_W = $clog2(ROTATE_CYC);
  localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [DW_W-1:0] DW_LAST  = DW_W'(ROTATE_CYC - 1);
  localparam logic [RC_W-1:0] REC_LAST = RC_W'(RECOVER_CYC - 1);

  logic [NUM_ERR-1:0]  err_filt_s;
  logic [NUM_ERR-1:0]  err_filt_next_s;
  logic [NUM_WARN-1:0] warn_next_unused_s;
  logic [NUM_ERR-1:0]  err_latched_r;
  logic [NUM_ERR-1:0]  err_next_s;
  logic                warn_any_s;

  for (genvar g = 0; g < NUM_ERR; g++) begin : g_err_filt
    fault_filter #(.FILTER_CYC(FILTER_CYC)) u_filt (
      .clk       (clk),
      .rst       (rst),
      .raw       (err_raw[g]),
      .filtered  (err_filt_s[g]),
      .filt_next (err_filt_next_s[g])
    );
  end

  for (genvar g = 0; g < NUM_WARN; g++) begin : g_warn_filt
    fault_filter #(.FILTER_CYC(FILTER_CYC)) u_filt (
      .clk       (clk),
      .rst       (rst),
      .raw       (warn_raw[g]),
      .filtered  (warn_active[g]),
      .filt_next (warn_next_unused_s[g])
    );
  end

  // Latch takes the filter's next value so it sets on the same edge the filter flips; set beats clear.
  always_comb begin
    err_next_s = err_latched_r;
    for (int i = 0; i < NUM_ERR; i++) begin
      if (err_filt_next_s[i]) begin
        err_next_s[i] = 1'b1;
      end else if (clear) begin
        err_next_s[i] = 1'b0;
      end else begin
        err_next_s[i] = err_latched_r[i];
      end
    end
  end

  // Sticky error latch register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_latched_r <= '0;
    end else begin
      err_latched_r <= err_next_s;
    end
  end

  assign err_latched    = err_latched_r;
  assign error_present  = |err_latched_r;
  assign critical_error = |(err_latched_r & CRIT_MASK);
  assign warn_any_s     = |warn_active;
  assign error_count    = EC_W'(popcount(MAX_CHANNELS'(err_latched_r)));
  assign warning_count  = WC_W'(popcount(MAX_CHANNELS'(warn_active)));

  // ---------------- display rotator ----------------
  logic [ID_W-1:0] disp_id_r;
  logic            disp_valid_r;
  logic [DW_W-1:0] dwell_r;
  logic [ID_W-1:0] lowest_s;
  logic [ID_W-1:0] above_s;
  logic [ID_W-1:0] step_s;
  logic            has_above_s;
  logic            hit_s;
  logic            cur_set_s;

  // Lowest set index overall and lowest set index strictly above the displayed one.
  always_comb begin
    lowest_s    = '0;
    above_s     = '0;
    has_above_s = 1'b0;
    hit_s       = 1'b0;
    for (int j = NUM_ERR - 1; j >= 0; j--) begin
      lowest_s    = err_latched_r[j] ? ID_W'(j) : lowest_s;
      hit_s       = err_latched_r[j] && (ID_W'(j) > disp_id_r);
      above_s     = hit_s ? ID_W'(j) : above_s;
      has_above_s = has_above_s | hit_s;
    end
    step_s    = has_above_s ? above_s : lowest_s;
    cur_set_s = err_latched_r[disp_id_r];
  end

  // Rotator registers: dwell restarts whenever the displayed index changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid_r <= 1'b0;
      disp_id_r    <= '0;
      dwell_r      <= '0;
    end else if (!error_present) begin
      disp_valid_r <= 1'b0;
      disp_id_r    <= '0;
      dwell_r      <= '0;
    end else if (!disp_valid_r) begin
      disp_valid_r <= 1'b1;
      disp_id_r    <= lowest_s;
      dwell_r      <= '0;
    end else if (!cur_set_s || (dwell_r == DW_LAST)) begin
      disp_id_r    <= step_s;
      dwell_r      <= '0;
    end else begin
      dwell_r      <= dwell_r + DW_W'(1);
    end
  end

  assign disp_valid = disp_valid_r & error_present;
  assign disp_id    = error_present ? disp_id_r : '0;

  // ---------------- health FSM ----------------
  state_t          state_r;
  state_t          state_next_s;
  logic [RC_W-1:0] rec_r;
  logic [RC_W-1:0] rec_next_s;

  // Next-state logic; the recover timer only runs while staying in S_RECOVER.
  always_comb begin
    state_next_s = state_r;
    rec_next_s   = '0;
    case (state_r)
      S_OK: begin
        if (error_present)   state_next_s = S_FAULT;
        else if (warn_any_s) state_next_s = S_WARN;
        else                 state_next_s = S_OK;
      end
      S_WARN: begin
        if (error_present)    state_next_s = S_FAULT;
        else if (!warn_any_s) state_next_s = S_OK;
        else                  state_next_s = S_WARN;
      end
      S_FAULT: begin
        if (!error_present) state_next_s = S_RECOVER;
        else                state_next_s = S_FAULT;
      end
      S_RECOVER: begin
        if (error_present)         state_next_s = S_FAULT;
        else if (rec_r == REC_LAST) state_next_s = warn_any_s ? S_WARN : S_OK;
        else                       state_next_s = S_RECOVER;
      end
      default: state_next_s = S_OK;
    endcase
    if ((state_r == S_RECOVER) && (state_next_s == S_RECOVER)) begin
      rec_next_s = rec_r + RC_W'(1);
    end else begin
      rec_next_s = '0;
    end
  end

  // FSM and recover timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_OK;
      rec_r   <= '0;
    end else begin
      state_r <= state_next_s;
      rec_r   <= rec_next_s;
    end
  end

  assign sys_state = state_r;

`ifdef FAULT_AGG_HISTORY_EN
  logic [7:0] hist_r [NUM_ERR];

  // Saturating occurrence counters, bumped on each rising edge of a latch bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ERR; i++) hist_r[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_ERR; i++) begin
        if (err_next_s[i] && !err_latched_r[i] && (hist_r[i] != 8'hFF)) begin
          hist_r[i] <= hist_r[i] + 8'd1;
        end
      end
    end
  end

  // Out-of-range selects match no entry and read back zero.
  always_comb begin
    hist_count = 8'd0;
    for (int i = 0; i < NUM_ERR; i++) begin
      hist_count = (hist_sel == ID_W'(i)) ? hist_r[i] : hist_count;
    end
  end
`endif

endmodule

// File: tb/tb_fault_aggregator.sv
// Scoreboard bench for fault_aggregator (FILTER_CYC=4, ROTATE_CYC=8, RECOVER_CYC=16).
// Expectations are queued with a cycle stamp and compared when that cycle is sampled.
module tb_fault_aggregator;
  import fault_agg_pkg::*;

  typedef enum int {SIG_LATCHED, SIG_WACT, SIG_CRIT, SIG_PRES, SIG_ECNT,
                    SIG_WCNT, SIG_DVALID, SIG_DID, SIG_STATE, SIG_HIST} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] err_raw = 6'd0;
  logic [5:0] warn_raw = 6'd0;
  logic       clear = 1'b0;
  logic [5:0] err_latched;
  logic [5:0] warn_active;
  logic       critical_error;
  logic       error_present;
  logic [2:0] error_count;
  logic [2:0] warning_count;
  logic       disp_valid;
  logic [2:0] disp_id;
  state_t     sys_state;
`ifdef FAULT_AGG_HISTORY_EN
  logic [2:0] hist_sel = 3'd0;
  logic [7:0] hist_count;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  fault_aggregator #(
    .NUM_ERR(6), .NUM_WARN(6), .CRIT_MASK(6'b000111),
    .FILTER_CYC(4), .ROTATE_CYC(8), .RECOVER_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .err_raw(err_raw), .warn_raw(warn_raw), .clear(clear),
    .err_latched(err_latched), .warn_active(warn_active),
    .critical_error(critical_error), .error_present(error_present),
    .error_count(error_count), .warning_count(warning_count),
    .disp_valid(disp_valid), .disp_id(disp_id),
`ifdef FAULT_AGG_HISTORY_EN
    .hist_sel(hist_sel), .hist_count(hist_count),
`endif
    .sys_state(sys_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input sig_e s);
    case (s)
      SIG_LATCHED: obs = 32'(err_latched);
      SIG_WACT:    obs = 32'(warn_active);
      SIG_CRIT:    obs = 32'(critical_error);
      SIG_PRES:    obs = 32'(error_present);
      SIG_ECNT:    obs = 32'(error_count);
      SIG_WCNT:    obs = 32'(warning_count);
      SIG_DVALID:  obs = 32'(disp_valid);
      SIG_DID:     obs = 32'(disp_id);
      SIG_STATE:   obs = 32'(sys_state);
`ifdef FAULT_AGG_HISTORY_EN
      SIG_HIST:    obs = 32'(hist_count);
`endif
      default:     obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int cyc, input sig_e s, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    for (int k = 0; k < 9; k++) expect_at(0, sig_e'(k), 32'd0, "reset_held");
    for (int k = 0; k < 9; k++) expect_at(1, sig_e'(k), 32'd0, "reset_released");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s/%s cyc=%0d got=%0h want=%0h", e.tag, e.sig.name(), c, got, e.val);
        end
      end
      if (c == 0) rst = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL reset_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_filter();
    exp_t e;
    logic [31:0] got;
    expect_at(12, SIG_LATCHED, 32'h00, "glitch3_ignored");
    expect_at(12, SIG_STATE,   32'(S_OK), "glitch3_state");
    expect_at(15, SIG_LATCHED, 32'h00, "filter_3_edges");
    expect_at(16, SIG_LATCHED, 32'h04, "filter_4_edges");
    expect_at(16, SIG_CRIT,    32'd1, "crit_err2");
    expect_at(16, SIG_PRES,    32'd1, "present_err2");
    expect_at(16, SIG_ECNT,    32'd1, "count_err2");
    expect_at(17, SIG_STATE,   32'(S_FAULT), "state_fault");
    expect_at(17, SIG_DVALID,  32'd1, "disp_valid_err2");
    expect_at(17, SIG_DID,     32'd2, "disp_id_err2");
    for (int c = 0; c < 18; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      if (c == 0)  err_raw = 6'b000100;
      if (c == 3)  err_raw = 6'b000000;
      if (c == 12) err_raw = 6'b000100;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL filter_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_clear();
    exp_t e;
    logic [31:0] got;
    expect_at(1,  SIG_LATCHED, 32'h04, "clear_while_active");
    expect_at(6,  SIG_LATCHED, 32'h00, "clear_inactive");
    expect_at(6,  SIG_PRES,    32'd0, "present_after_clear");
    expect_at(6,  SIG_STATE,   32'(S_FAULT), "fault_one_more");
    expect_at(7,  SIG_STATE,   32'(S_RECOVER), "recover_entry");
    expect_at(7,  SIG_DVALID,  32'd0, "disp_valid_none");
    expect_at(22, SIG_STATE,   32'(S_RECOVER), "recover_15");
    expect_at(23, SIG_STATE,   32'(S_OK), "recover_exit_ok");
    for (int c = 0; c < 24; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      if (c == 0) clear = 1'b1;
      if (c == 1) begin clear = 1'b0; err_raw = 6'b000000; end
      if (c == 5) clear = 1'b1;
      if (c == 6) clear = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL clear_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_rotate();
    exp_t e;
    logic [31:0] got;
    expect_at(4,  SIG_LATCHED, 32'h32, "rot_latched");
    expect_at(4,  SIG_ECNT,    32'd3, "rot_count");
    expect_at(4,  SIG_CRIT,    32'd1, "rot_crit");
    expect_at(5,  SIG_DVALID,  32'd1, "rot_valid");
    expect_at(5,  SIG_DID,     32'd1, "rot_first");
    expect_at(12, SIG_DID,     32'd1, "rot_dwell1");
    expect_at(13, SIG_DID,     32'd4, "rot_to4");
    expect_at(20, SIG_DID,     32'd4, "rot_dwell4");
    expect_at(21, SIG_DID,     32'd5, "rot_to5");
    expect_at(28, SIG_DID,     32'd5, "rot_dwell5");
    expect_at(29, SIG_DID,     32'd1, "rot_wrap1");
    expect_at(37, SIG_DID,     32'd4, "rot_again4");
    expect_at(38, SIG_LATCHED, 32'h22, "rot_cleared4");
    expect_at(38, SIG_DID,     32'd4, "rot_lag");
    expect_at(39, SIG_DID,     32'd5, "rot_skip_to5");
    expect_at(46, SIG_DID,     32'd5, "rot_dwell_restart");
    expect_at(47, SIG_DID,     32'd1, "rot_after_restart");
    expect_at(52, SIG_LATCHED, 32'h00, "rot_all_cleared");
    expect_at(53, SIG_STATE,   32'(S_RECOVER), "rot_recover");
    expect_at(69, SIG_STATE,   32'(S_OK), "rot_ok");
    for (int c = 0; c < 70; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      if (c == 0)  err_raw = 6'b110010;
      if (c == 4)  err_raw = 6'b100010;
      if (c == 37) clear = 1'b1;
      if (c == 38) clear = 1'b0;
      if (c == 47) err_raw = 6'b000000;
      if (c == 51) clear = 1'b1;
      if (c == 52) clear = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rotate_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_warn();
    exp_t e;
    logic [31:0] got;
    expect_at(4,  SIG_WACT,    32'h03, "warn_active");
    expect_at(4,  SIG_WCNT,    32'd2, "warn_count");
    expect_at(4,  SIG_STATE,   32'(S_OK), "warn_state_lag");
    expect_at(5,  SIG_STATE,   32'(S_WARN), "warn_state");
    expect_at(5,  SIG_CRIT,    32'd0, "warn_no_crit");
    expect_at(5,  SIG_PRES,    32'd0, "warn_no_err");
    expect_at(9,  SIG_LATCHED, 32'h01, "warn_err0");
    expect_at(9,  SIG_CRIT,    32'd1, "warn_crit0");
    expect_at(10, SIG_STATE,   32'(S_FAULT), "warn_to_fault");
    expect_at(14, SIG_WACT,    32'h00, "warn_gone");
    expect_at(14, SIG_WCNT,    32'd0, "warn_count0");
    expect_at(15, SIG_LATCHED, 32'h00, "warn_err_cleared");
    expect_at(16, SIG_STATE,   32'(S_RECOVER), "warn_recover");
    expect_at(32, SIG_STATE,   32'(S_OK), "warn_ok");
    for (int c = 0; c < 33; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      if (c == 0)  warn_raw = 6'b000011;
      if (c == 5)  err_raw = 6'b000001;
      if (c == 10) begin err_raw = 6'b000000; warn_raw = 6'b000000; end
      if (c == 14) clear = 1'b1;
      if (c == 15) clear = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL warn_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_recover_reset();
    exp_t e;
    logic [31:0] got;
    expect_at(4,  SIG_LATCHED, 32'h08, "rr_latch3");
    expect_at(4,  SIG_CRIT,    32'd0, "rr_mask_noncrit");
    expect_at(5,  SIG_STATE,   32'(S_FAULT), "rr_fault");
    expect_at(10, SIG_LATCHED, 32'h00, "rr_cleared");
    expect_at(11, SIG_STATE,   32'(S_RECOVER), "rr_recover");
    expect_at(15, SIG_LATCHED, 32'h08, "rr_relatch");
    expect_at(15, SIG_STATE,   32'(S_RECOVER), "rr_still_recover");
    expect_at(16, SIG_STATE,   32'(S_FAULT), "rr_back_fault");
    expect_at(17, SIG_LATCHED, 32'h00, "rr_rst_latched");
    expect_at(17, SIG_STATE,   32'(S_OK), "rr_rst_state");
    expect_at(17, SIG_DVALID,  32'd0, "rr_rst_dvalid");
    expect_at(17, SIG_PRES,    32'd0, "rr_rst_present");
    expect_at(17, SIG_ECNT,    32'd0, "rr_rst_count");
    expect_at(18, SIG_LATCHED, 32'h00, "rr_rel_latched");
    expect_at(18, SIG_STATE,   32'(S_OK), "rr_rel_state");
    expect_at(21, SIG_LATCHED, 32'h00, "rr_rel_3");
    expect_at(22, SIG_LATCHED, 32'h08, "rr_rel_4");
    expect_at(27, SIG_LATCHED, 32'h00, "rr_cleanup");
    expect_at(28, SIG_STATE,   32'(S_RECOVER), "rr_cleanup_rec");
    expect_at(44, SIG_STATE,   32'(S_OK), "rr_cleanup_ok");
    for (int c = 0; c < 45; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      if (c == 0)  err_raw = 6'b001000;
      if (c == 5)  err_raw = 6'b000000;
      if (c == 9)  clear = 1'b1;
      if (c == 10) clear = 1'b0;
      if (c == 11) err_raw = 6'b001000;
      if (c == 16) rst = 1'b1;
      if (c == 18) rst = 1'b0;
      if (c == 22) err_raw = 6'b000000;
      if (c == 26) clear = 1'b1;
      if (c == 27) clear = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rr_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask

`ifdef FAULT_AGG_HISTORY_EN
  task automatic test_history();
    exp_t e;
    logic [31:0] got;
    int p;
    expect_at(32,   SIG_HIST, 32'd3, "hist_three");
    expect_at(33,   SIG_HIST, 32'd0, "hist_sel_oob");
    expect_at(34,   SIG_HIST, 32'd0, "hist_other_zero");
    expect_at(3038, SIG_HIST, 32'd255, "hist_saturate");
    for (int c = 0; c < 3039; c++) begin
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); got = obs(e.sig); checks++;
        if (got !== e.val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h", e.tag, c, got, e.val);
        end
      end
      p = -1;
      if (c >= 2 && c < 32)    p = (c - 2) % 10;
      if (c >= 35 && c < 3035) p = (c - 35) % 10;
      if (c == 0)  rst = 1'b1;
      if (c == 1)  rst = 1'b0;
      if (c == 32) hist_sel = 3'd6;
      if (c == 33) hist_sel = 3'd2;
      if (c == 34) hist_sel = 3'd0;
      if (p == 0) err_raw = 6'b000001;
      if (p == 4) err_raw = 6'b000000;
      if (p == 8) clear = 1'b1;
      if (p == 9) clear = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL hist_leftover got=%0d want=0", sb.size()); sb.delete(); end
  endtask
`endif

  initial begin
    test_reset();
    test_filter();
    test_clear();
    test_rotate();
    test_warn();
    test_recover_reset();
`ifdef FAULT_AGG_HISTORY_EN
    test_history();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
